// File: rtl/lmem_pingpong_buf.sv
// Ping-pong LLR buffer: two banks per circulant channel, registered inputs, 2-cycle read, optional write-back.
// Define LMEM_OOR_ERR_EN to also flag out-of-range read addresses in err_regout.
module lmem_pingpong_buf #(
   parameter int W            = 6,
   parameter int P            = 26,
   parameter int Nb           = 16,
   parameter int Wt           = 2,
   parameter int DEPTH        = 20,
   parameter int ADDRESSWIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en_regin,
   input  logic [P*Nb*Wt*W-1:0]    wr_data_regin,
   input  logic                    rd_en_regin,
   input  logic [ADDRESSWIDTH-1:0] rd_address_regin,
   input  logic                    feedback_en_regin,
   input  logic                    swap_regin,
   output logic [P*Nb*Wt*W-1:0]    rd_data_regout,
   output logic                    rd_valid_regout,
   output logic                    wr_full_regout,
   output logic                    err_regout
);

   localparam int LW  = Wt * W;
   localparam int SW  = Nb * LW;
   localparam int BW  = P * SW;
   localparam int CW  = P * LW;
   localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW  = $clog2(DEPTH + 1);

   localparam logic [PW-1:0]           DEPTH_P = PW'(DEPTH);
   localparam logic [ADDRESSWIDTH:0]   DEPTH_A = (ADDRESSWIDTH + 1)'(DEPTH);

   // stage 0 input registers
   logic                    wr_en_q;
   logic [BW-1:0]           wr_data_q;
   logic                    rd_en_q;
   logic [ADDRESSWIDTH-1:0] rd_addr_q;
   logic                    fb_en_q;
   logic                    swap_q;

   // write-side state and output registers
   logic            wr_bank_q, wr_bank_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic            wr_full_q, wr_full_d;
   logic            err_q, err_d;
   logic [BW-1:0]   rd_data_q, rd_data_d;
   logic            rd_valid_q, rd_valid_d;

   // read pipeline stage 1
   logic            rd_v1_q;
   logic            fb_v1_q;
   logic [CW-1:0]   rd_word_q [Nb];

   logic [CW-1:0]   mem_q [2][Nb][DEPTH];

   logic [CW-1:0]   wr_chan   [Nb];
   logic [CW-1:0]   mem_wdata [Nb];
   logic [BW-1:0]   rd_bus;
   logic            rd_bank;
   logic            rd_oor;
   logic [MAW-1:0]  rd_idx;
   logic [MAW-1:0]  wr_idx;
   logic            wr_req;
   logic            mem_we;
   logic            collide;
   logic            wr_drop_full;
   logic            oor_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         fb_en_q   <= 1'b0;
         swap_q    <= 1'b0;
      end else begin
         wr_en_q   <= wr_en_regin;
         wr_data_q <= wr_data_regin;
         rd_en_q   <= rd_en_regin;
         rd_addr_q <= rd_address_regin;
         fb_en_q   <= feedback_en_regin;
         swap_q    <= swap_regin;
      end
   end

   // bus slice j, channel i  <->  channel word bits [j*LW +: LW]
   always_comb begin
      for (int i = 0; i < Nb; i++) begin
         wr_chan[i] = '0;
         for (int j = 0; j < P; j++) begin
            wr_chan[i][j*LW +: LW] = wr_data_q[j*SW + i*LW +: LW];
         end
      end
   end

   always_comb begin
      rd_bus = '0;
      for (int i = 0; i < Nb; i++) begin
         for (int j = 0; j < P; j++) begin
            rd_bus[j*SW + i*LW +: LW] = rd_word_q[i][j*LW +: LW];
         end
      end
   end

   assign rd_bank = ~wr_bank_q;
   assign rd_oor  = ({1'b0, rd_addr_q} >= DEPTH_A);
   assign rd_idx  = rd_addr_q[MAW-1:0];
   assign wr_idx  = wr_ptr_q[MAW-1:0];

`ifdef LMEM_OOR_ERR_EN
   assign oor_err = rd_en_q & rd_oor;
`else
   assign oor_err = 1'b0;
`endif

   // a pending write-back always takes the write port over a fresh write
   assign wr_req       = fb_v1_q | wr_en_q;
   assign collide      = fb_v1_q & wr_en_q;
   assign wr_drop_full = wr_req & wr_full_q;
   assign mem_we       = wr_req & ~wr_full_q;

   always_comb begin
      for (int i = 0; i < Nb; i++) begin
         mem_wdata[i] = fb_v1_q ? rd_word_q[i] : wr_chan[i];
      end
   end

   always_comb begin
      wr_bank_d  = wr_bank_q;
      wr_ptr_d   = wr_ptr_q;
      wr_full_d  = wr_full_q;
      err_d      = err_q | wr_drop_full | collide | oor_err;
      rd_valid_d = rd_v1_q;
      rd_data_d  = rd_data_q;
      if (mem_we) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         if (wr_ptr_d == DEPTH_P) begin
            wr_full_d = 1'b1;
         end
      end
      // swap is applied after the write, so a coincident write lands in the old bank
      if (swap_q) begin
         wr_bank_d = ~wr_bank_q;
         wr_ptr_d  = '0;
         wr_full_d = 1'b0;
      end
      if (rd_v1_q) begin
         rd_data_d = rd_bus;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_bank_q  <= 1'b0;
         wr_ptr_q   <= '0;
         wr_full_q  <= 1'b0;
         err_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_v1_q    <= 1'b0;
         fb_v1_q    <= 1'b0;
      end else begin
         wr_bank_q  <= wr_bank_d;
         wr_ptr_q   <= wr_ptr_d;
         wr_full_q  <= wr_full_d;
         err_q      <= err_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_v1_q    <= rd_en_q;
         fb_v1_q    <= rd_en_q & fb_en_q;
      end
   end

   // storage and the read word are not reset; validity is carried by rd_v1_q
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < Nb; i++) begin
            mem_q[wr_bank_q][i][wr_idx] <= mem_wdata[i];
         end
      end
      if (rd_en_q) begin
         for (int i = 0; i < Nb; i++) begin
            rd_word_q[i] <= rd_oor ? '0 : mem_q[rd_bank][i][rd_idx];
         end
      end
   end

   assign rd_data_regout  = rd_data_q;
   assign rd_valid_regout = rd_valid_q;
   assign wr_full_regout  = wr_full_q;
   assign err_regout      = err_q;

endmodule

// File: tb/tb_lmem_pingpong_buf.sv
// Directed bench for lmem_pingpong_buf: fill/swap/read, overflow, swap+write, write-back collision, OOR read, reset mid-read.
module tb_lmem_pingpong_buf;

   localparam int W     = 6;
   localparam int P     = 26;
   localparam int Nb    = 16;
   localparam int Wt    = 2;
   localparam int DEPTH = 20;
   localparam int AW    = 5;
   localparam int LW    = Wt * W;
   localparam int SW    = Nb * LW;
   localparam int BW    = P * SW;

   logic          clk;
   logic          rst;
   logic          wr_en_regin;
   logic [BW-1:0] wr_data_regin;
   logic          rd_en_regin;
   logic [AW-1:0] rd_address_regin;
   logic          feedback_en_regin;
   logic          swap_regin;
   logic [BW-1:0] rd_data_regout;
   logic          rd_valid_regout;
   logic          wr_full_regout;
   logic          err_regout;

   int total;
   int passed;
   int failed;

   lmem_pingpong_buf #(
      .W(W), .P(P), .Nb(Nb), .Wt(Wt), .DEPTH(DEPTH), .ADDRESSWIDTH(AW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .wr_en_regin       (wr_en_regin),
      .wr_data_regin     (wr_data_regin),
      .rd_en_regin       (rd_en_regin),
      .rd_address_regin  (rd_address_regin),
      .feedback_en_regin (feedback_en_regin),
      .swap_regin        (swap_regin),
      .rd_data_regout    (rd_data_regout),
      .rd_valid_regout   (rd_valid_regout),
      .wr_full_regout    (wr_full_regout),
      .err_regout        (err_regout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // every lane of every word gets a distinct 12-bit value
   function automatic logic [LW-1:0] lane(input int seed, input int j, input int i);
      return LW'((seed * 416 + j * Nb + i) * 7 + 3);
   endfunction

   function automatic logic [BW-1:0] mk(input int seed);
      logic [BW-1:0] b;
      b = '0;
      for (int j = 0; j < P; j++) begin
         for (int i = 0; i < Nb; i++) begin
            b[j*SW + i*LW +: LW] = lane(seed, j, i);
         end
      end
      return b;
   endfunction

   function automatic logic [31:0] fold(input logic [BW-1:0] b);
      logic [31:0] f;
      f = '0;
      for (int k = 0; k < BW / 32; k++) begin
         f = f ^ b[k*32 +: 32];
      end
      return f;
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chkl(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chkbus(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed fold %0h low %0h expected fold %0h low %0h",
                tag, fold(obs), obs[63:0], fold(exp), exp[63:0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_wr(input int seed);
      wr_en_regin   = 1'b1;
      wr_data_regin = mk(seed);
      step();
      wr_en_regin   = 1'b0;
   endtask

   task automatic do_swap();
      swap_regin = 1'b1;
      step();
      swap_regin = 1'b0;
      step();
   endtask

   task automatic do_rd(input string tag, input int addr, input logic [BW-1:0] exp);
      rd_address_regin = AW'(addr);
      rd_en_regin      = 1'b1;
      step();
      rd_en_regin      = 1'b0;
      step();
      chk1({tag, "_valid_early"}, rd_valid_regout, 1'b0);
      step();
      chk1({tag, "_valid"}, rd_valid_regout, 1'b1);
      chkbus({tag, "_data"}, rd_data_regout, exp);
   endtask

   task automatic check_all_zero(input string tag);
      chk1({tag, "_valid"}, rd_valid_regout, 1'b0);
      chk1({tag, "_full"}, wr_full_regout, 1'b0);
      chk1({tag, "_err"}, err_regout, 1'b0);
      chkbus({tag, "_data"}, rd_data_regout, '0);
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      check_all_zero("reset");
      step();
      #2 rst = 1'b1;
      step();
   endtask

   initial begin
      total = 0;
      passed = 0;
      failed = 0;
      rst = 1'b0;
      wr_en_regin = 1'b0;
      wr_data_regin = '0;
      rd_en_regin = 1'b0;
      rd_address_regin = '0;
      feedback_en_regin = 1'b0;
      swap_regin = 1'b0;

      step();
      step();
      check_all_zero("por");
      #2 rst = 1'b1;
      step();

      // fill bank 0, swap, read back in order
      for (int n = 0; n < DEPTH; n++) do_wr(n);
      step();
      chk1("fill_full", wr_full_regout, 1'b1);
      chk1("fill_err", err_regout, 1'b0);
      do_swap();
      chk1("swap_clears_full", wr_full_regout, 1'b0);
      for (int n = 0; n < DEPTH; n++) do_rd($sformatf("rdA%0d", n), n, mk(n));
      chkl("lane_j25_i15", rd_data_regout[(P-1)*SW + (Nb-1)*LW +: LW], lane(DEPTH - 1, P - 1, Nb - 1));
      chkl("lane_j0_i1", rd_data_regout[1*LW +: LW], lane(DEPTH - 1, 0, 1));
      chkl("lane_j3_i0", rd_data_regout[3*SW +: LW], lane(DEPTH - 1, 3, 0));
      step();
      chk1("hold_valid", rd_valid_regout, 1'b0);
      chkbus("hold_data", rd_data_regout, mk(DEPTH - 1));

      // overflow bank 1 with a 21st write
      for (int n = 0; n < DEPTH; n++) do_wr(100 + n);
      step();
      chk1("ovf_full20", wr_full_regout, 1'b1);
      chk1("ovf_err20", err_regout, 1'b0);
      do_wr(150);
      step();
      chk1("ovf_err21", err_regout, 1'b1);
      chk1("ovf_full21", wr_full_regout, 1'b1);
      do_swap();
      do_rd("ovf_a0", 0, mk(100));
      do_rd("ovf_a19", 19, mk(119));

      // swap coincident with the write to address 19 of bank 0
      do_reset();
      for (int n = 0; n < DEPTH - 1; n++) do_wr(50 + n);
      wr_en_regin   = 1'b1;
      wr_data_regin = mk(200);
      swap_regin    = 1'b1;
      step();
      wr_en_regin   = 1'b0;
      swap_regin    = 1'b0;
      step();
      chk1("sw_full", wr_full_regout, 1'b0);
      do_rd("sw_old19", 19, mk(200));
      do_rd("sw_old0", 0, mk(50));
      do_swap();
      do_rd("sw_new0", 0, mk(100));
      do_rd("sw_new19", 19, mk(119));
      chk1("sw_err", err_regout, 1'b0);

      // write-back of address 3 collides with a fresh write
      rd_address_regin  = AW'(3);
      rd_en_regin       = 1'b1;
      feedback_en_regin = 1'b1;
      step();
      rd_en_regin       = 1'b0;
      feedback_en_regin = 1'b0;
      wr_en_regin       = 1'b1;
      wr_data_regin     = mk(201);
      step();
      wr_en_regin       = 1'b0;
      chk1("fb_valid_early", rd_valid_regout, 1'b0);
      step();
      chk1("fb_valid", rd_valid_regout, 1'b1);
      chkbus("fb_data", rd_data_regout, mk(103));
      chk1("fb_err", err_regout, 1'b1);
      step();
      chk1("fb_pulse", rd_valid_regout, 1'b0);
      do_swap();
      do_rd("fb_slot0", 0, mk(103));
      do_rd("fb_slot1", 1, mk(51));

      // out-of-range read
      do_reset();
      do_rd("pre_oor", 5, mk(105));
      do_rd("oor", 25, '0);
`ifdef LMEM_OOR_ERR_EN
      chk1("oor_err", err_regout, 1'b1);
`else
      chk1("oor_err", err_regout, 1'b0);
`endif

      // reset between rd_en and valid
      do_rd("pre_rst", 2, mk(102));
      rd_address_regin = AW'(7);
      rd_en_regin      = 1'b1;
      step();
      rd_en_regin      = 1'b0;
      #2 rst = 1'b0;
      #1;
      check_all_zero("mid_rst");
      step();
      #2 rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk1($sformatf("post_rst_valid%0d", c), rd_valid_regout, 1'b0);
      end
      chkbus("post_rst_data", rd_data_regout, '0);
      do_rd("post_rst_rd", 7, mk(107));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
